// File: rtl/fadd_pipe_ctrl.sv
// Valid/tag tracking and stage-enable control for a three-register fadd/fsub pipeline.
// Bubbles collapse through a combinational ready chain; flush and rst discard in-flight work.
module fadd_pipe_ctrl #(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush,
  output logic             e_ac,
  output logic             e_cn,
  output logic             e_out,
  output logic [1:0]       occupancy,
  output logic             idle,
  output logic [CNT_W-1:0] retired
);

  logic             v1, v2, v3;
  logic [TAG_W-1:0] t1, t2, t3;
  logic [CNT_W-1:0] cnt;
  logic             r1, r2, r3;
  logic             fire;

  // Ready chain: a stage can load when empty or when its successor is draining.
  always_comb begin
    r3       = !v3 | out_ready;
    r2       = !v2 | r3;
    r1       = !v1 | r2;
    in_ready = r1 & !flush & !rst;
    e_ac     = in_valid & in_ready;
    e_cn     = v1 & r2 & !flush & !rst;
    e_out    = v2 & r3 & !flush & !rst;
    fire     = v3 & out_ready & !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      t1  <= '0;
      t2  <= '0;
      t3  <= '0;
      cnt <= '0;
    end else if (flush) begin
      // Kill all in-flight operations; tags are left as-is.
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (r1) v1 <= in_valid;
      if (r2) v2 <= v1;
      if (r3) v3 <= v2;
      if (e_ac)  t1 <= in_tag;
      if (e_cn)  t2 <= t1;
      if (e_out) t3 <= t2;
      if (fire)  cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    out_valid = v3;
    out_tag   = t3;
    occupancy = 2'(v1) + 2'(v2) + 2'(v3);
    idle      = (occupancy == 2'd0);
    retired   = cnt;
  end

endmodule

// File: tb/tb_fadd_pipe_ctrl.sv
// Directed and randomized checks of fadd_pipe_ctrl: latency, stalls, throughput, flush,
// reset, counter wrap (second instance with a 4-bit counter) and queue-order stress.
module tb_fadd_pipe_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [4:0] in_tag;
  logic       out_ready;
  logic       flush;

  logic        in_ready, out_valid, e_ac, e_cn, e_out, idle;
  logic [4:0]  out_tag;
  logic [1:0]  occupancy;
  logic [15:0] retired;

  logic        in_ready_b, out_valid_b, e_ac_b, e_cn_b, e_out_b, idle_b;
  logic [4:0]  out_tag_b;
  logic [1:0]  occupancy_b;
  logic [3:0]  retired_b;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int exp_ret  = 0;

  fadd_pipe_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_tag(in_tag), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .flush(flush),
    .e_ac(e_ac), .e_cn(e_cn), .e_out(e_out), .occupancy(occupancy), .idle(idle),
    .retired(retired)
  );

  fadd_pipe_ctrl #(.TAG_W(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_tag(in_tag), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_tag(out_tag_b), .flush(flush),
    .e_ac(e_ac_b), .e_cn(e_cn_b), .e_out(e_out_b), .occupancy(occupancy_b), .idle(idle_b),
    .retired(retired_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_tag = 5'd9; out_ready = 1'b1; flush = 1'b0;
    cyc(); #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %0b exp 0", in_ready); else pass_cnt++;
    chk_cnt++; if (e_ac !== 1'b0) $display("FAIL rst_e_ac got %0b exp 0", e_ac); else pass_cnt++;
    chk_cnt++; if (e_cn !== 1'b0 || e_out !== 1'b0) $display("FAIL rst_e_cn_out got %0b%0b exp 00", e_cn, e_out); else pass_cnt++;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_tag !== 5'd0) $display("FAIL rst_out_tag got %0d exp 0", out_tag); else pass_cnt++;
    chk_cnt++; if (occupancy !== 2'd0) $display("FAIL rst_occupancy got %0d exp 0", occupancy); else pass_cnt++;
    chk_cnt++; if (idle !== 1'b1) $display("FAIL rst_idle got %0b exp 1", idle); else pass_cnt++;
    chk_cnt++; if (retired !== 16'd0 || retired_b !== 4'd0) $display("FAIL rst_retired got %0d/%0d exp 0", retired, retired_b); else pass_cnt++;
    exp_ret = 0;
  endtask

  task automatic test_single();
    cyc();
    in_valid = 1'b1; in_tag = 5'd5; out_ready = 1'b1;
    #1;
    chk_cnt++; if (e_ac !== 1'b1) $display("FAIL single_e_ac got %0b exp 1", e_ac); else pass_cnt++;
    cyc();
    in_valid = 1'b0;
    #1;
    chk_cnt++; if (e_ac !== 1'b0 || e_cn !== 1'b1) $display("FAIL single_e_cn got ac=%0b cn=%0b exp ac=0 cn=1", e_ac, e_cn); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL single_early_valid got %0b exp 0", out_valid); else pass_cnt++;
    cyc(); #1;
    chk_cnt++; if (e_out !== 1'b1 || out_valid !== 1'b0) $display("FAIL single_e_out got e_out=%0b ov=%0b exp 1/0", e_out, out_valid); else pass_cnt++;
    cyc(); #1;
    chk_cnt++; if (out_valid !== 1'b1 || out_tag !== 5'd5) $display("FAIL single_result got ov=%0b tag=%0d exp 1/5", out_valid, out_tag); else pass_cnt++;
    chk_cnt++; if (retired !== 16'(exp_ret)) $display("FAIL single_pre_ret got %0d exp %0d", retired, exp_ret); else pass_cnt++;
    exp_ret++;
    cyc(); #1;
    chk_cnt++; if (retired !== 16'(exp_ret) || out_valid !== 1'b0 || idle !== 1'b1) $display("FAIL single_post got ret=%0d ov=%0b idle=%0b exp %0d/0/1", retired, out_valid, idle, exp_ret); else pass_cnt++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      in_valid = 1'b1; in_tag = 5'(i);
      #1;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL stall_fill_ready%0d got %0b exp 1", i, in_ready); else pass_cnt++;
    end
    cyc();
    in_tag = 5'd4;
    #1;
    chk_cnt++; if (occupancy !== 2'd3 || in_ready !== 1'b0 || e_ac !== 1'b0) $display("FAIL stall_full got occ=%0d rdy=%0b eac=%0b exp 3/0/0", occupancy, in_ready, e_ac); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b1 || out_tag !== 5'd1) $display("FAIL stall_head got ov=%0b tag=%0d exp 1/1", out_valid, out_tag); else pass_cnt++;
    cyc(); #1;
    chk_cnt++; if (in_ready !== 1'b0 || out_tag !== 5'd1 || out_valid !== 1'b1) $display("FAIL stall_hold got rdy=%0b tag=%0d ov=%0b exp 0/1/1", in_ready, out_tag, out_valid); else pass_cnt++;
    cyc();
    out_ready = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b1 || out_tag !== 5'd1) $display("FAIL stall_release got rdy=%0b tag=%0d exp 1/1", in_ready, out_tag); else pass_cnt++;
    exp_ret++;
    for (int j = 2; j <= 4; j++) begin
      cyc();
      in_valid = 1'b0;
      #1;
      chk_cnt++; if (out_valid !== 1'b1 || out_tag !== 5'(j)) $display("FAIL stall_order%0d got ov=%0b tag=%0d exp 1/%0d", j, out_valid, out_tag, j); else pass_cnt++;
      chk_cnt++; if (occupancy !== 2'(5 - j)) $display("FAIL stall_occ%0d got %0d exp %0d", j, occupancy, 5 - j); else pass_cnt++;
      exp_ret++;
    end
    cyc(); #1;
    chk_cnt++; if (idle !== 1'b1 || retired !== 16'(exp_ret)) $display("FAIL stall_done got idle=%0b ret=%0d exp 1/%0d", idle, retired, exp_ret); else pass_cnt++;
  endtask

  task automatic test_throughput();
    out_ready = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      cyc();
      in_valid = 1'b1; in_tag = 5'(10 + k);
      #1;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL thru_ready%0d got %0b exp 1", k, in_ready); else pass_cnt++;
      if (k >= 3) begin
        chk_cnt++; if (occupancy !== 2'd3 || out_valid !== 1'b1) $display("FAIL thru_occ%0d got occ=%0d ov=%0b exp 3/1", k, occupancy, out_valid); else pass_cnt++;
        chk_cnt++; if (out_tag !== 5'(k + 7)) $display("FAIL thru_tag%0d got %0d exp %0d", k, out_tag, k + 7); else pass_cnt++;
        chk_cnt++; if (retired !== 16'(exp_ret)) $display("FAIL thru_ret%0d got %0d exp %0d", k, retired, exp_ret); else pass_cnt++;
        exp_ret++;
      end
    end
    for (int k = 13; k <= 15; k++) begin
      cyc();
      in_valid = 1'b0;
      #1;
      chk_cnt++; if (out_valid !== 1'b1 || out_tag !== 5'(k + 7)) $display("FAIL thru_drain%0d got ov=%0b tag=%0d exp 1/%0d", k, out_valid, out_tag, k + 7); else pass_cnt++;
      exp_ret++;
    end
    cyc(); #1;
    chk_cnt++; if (idle !== 1'b1 || retired !== 16'(exp_ret)) $display("FAIL thru_done got idle=%0b ret=%0d exp 1/%0d", idle, retired, exp_ret); else pass_cnt++;
  endtask

  task automatic test_flush();
    cyc();
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 5'd7;
    cyc();
    in_tag = 5'd8;
    cyc();
    in_valid = 1'b0;
    cyc();
    flush = 1'b1; in_valid = 1'b1; in_tag = 5'd9; out_ready = 1'b1;
    #1;
    chk_cnt++; if (occupancy !== 2'd2 || out_valid !== 1'b1) $display("FAIL flush_pre got occ=%0d ov=%0b exp 2/1", occupancy, out_valid); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0 || e_ac !== 1'b0) $display("FAIL flush_accept got rdy=%0b eac=%0b exp 0/0", in_ready, e_ac); else pass_cnt++;
    chk_cnt++; if (e_cn !== 1'b0 || e_out !== 1'b0) $display("FAIL flush_enables got cn=%0b out=%0b exp 0/0", e_cn, e_out); else pass_cnt++;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk_cnt++; if (occupancy !== 2'd0 || idle !== 1'b1 || out_valid !== 1'b0) $display("FAIL flush_empty got occ=%0d idle=%0b ov=%0b exp 0/1/0", occupancy, idle, out_valid); else pass_cnt++;
    chk_cnt++; if (retired !== 16'(exp_ret)) $display("FAIL flush_no_fire got %0d exp %0d", retired, exp_ret); else pass_cnt++;
    chk_cnt++; if (out_tag !== 5'd7) $display("FAIL flush_tag_hold got %0d exp 7", out_tag); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    cyc();
    in_valid = 1'b1; in_tag = 5'd3; out_ready = 1'b0;
    cyc();
    in_tag = 5'd6;
    cyc();
    rst = 1'b1;
    #1;
    chk_cnt++; if (occupancy !== 2'd2) $display("FAIL mrst_pre_occ got %0d exp 2", occupancy); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0 || e_ac !== 1'b0 || e_cn !== 1'b0 || e_out !== 1'b0) $display("FAIL mrst_enables got %0b%0b%0b%0b exp 0000", in_ready, e_ac, e_cn, e_out); else pass_cnt++;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk_cnt++; if (occupancy !== 2'd0 || out_tag !== 5'd0) $display("FAIL mrst_state got occ=%0d tag=%0d exp 0/0", occupancy, out_tag); else pass_cnt++;
    chk_cnt++; if (retired !== 16'd0 || retired_b !== 4'd0) $display("FAIL mrst_retired got %0d/%0d exp 0", retired, retired_b); else pass_cnt++;
    exp_ret = 0;
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      cyc();
      in_valid = (c < 17); in_tag = 5'(c);
      #1;
      chk_cnt++; if (retired_b !== 4'(exp_ret) || retired !== 16'(exp_ret)) $display("FAIL wrap_ret%0d got %0d/%0d exp %0d", c, retired_b, retired, exp_ret); else pass_cnt++;
      if (c >= 3 && c < 20) begin
        chk_cnt++; if (out_valid !== 1'b1 || out_tag !== 5'(c - 3)) $display("FAIL wrap_tag%0d got ov=%0b tag=%0d exp 1/%0d", c, out_valid, out_tag, c - 3); else pass_cnt++;
        exp_ret++;
      end
    end
    chk_cnt++; if (retired_b !== 4'd1 || retired !== 16'd17) $display("FAIL wrap_final got %0d/%0d exp 1/17", retired_b, retired); else pass_cnt++;
  endtask

  task automatic test_stress();
    logic [4:0] q[$];
    logic       exp_rdy;
    for (int n = 0; n < 600; n++) begin
      cyc();
      flush     = ($urandom_range(15) == 0);
      in_valid  = ($urandom_range(9) < 6);
      out_ready = ($urandom_range(9) < 6);
      in_tag    = 5'($urandom_range(31));
      #1;
      exp_rdy = !flush && !(q.size() == 3 && !out_ready);
      chk_cnt++; if (occupancy !== 2'(q.size()) || occupancy_b !== 2'(q.size())) $display("FAIL stress_occ%0d got %0d exp %0d", n, occupancy, q.size()); else pass_cnt++;
      chk_cnt++; if (in_ready !== exp_rdy || in_ready_b !== exp_rdy) $display("FAIL stress_ready%0d got %0b exp %0b", n, in_ready, exp_rdy); else pass_cnt++;
      chk_cnt++; if (e_ac !== (in_valid & exp_rdy)) $display("FAIL stress_e_ac%0d got %0b exp %0b", n, e_ac, in_valid & exp_rdy); else pass_cnt++;
      chk_cnt++; if ((e_cn || e_out) && (flush || q.size() == 0)) $display("FAIL stress_spurious_en%0d got cn=%0b out=%0b exp 0", n, e_cn, e_out); else pass_cnt++;
      chk_cnt++; if (out_valid && q.size() == 0) $display("FAIL stress_phantom%0d got ov=1 exp 0", n); else pass_cnt++;
      if (out_valid && q.size() != 0) begin
        chk_cnt++; if (out_tag !== q[0] || out_tag_b !== q[0]) $display("FAIL stress_tag%0d got %0d exp %0d", n, out_tag, q[0]); else pass_cnt++;
      end
      if (flush) q.delete();
      else begin
        if (out_valid && out_ready && q.size() != 0) begin
          void'(q.pop_front());
          exp_ret++;
        end
        if (in_valid && exp_rdy) q.push_back(in_tag);
      end
    end
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk_cnt++; if (retired !== 16'(exp_ret) || retired_b !== 4'(exp_ret)) $display("FAIL stress_ret got %0d/%0d exp %0d", retired, retired_b, exp_ret); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_tag = '0; out_ready = 1'b0; flush = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_throughput();
    test_flush();
    test_mid_reset();
    test_wrap();
    test_stress();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
